// File: rtl/bf16_norm_arb.sv
// Shared BFloat16 normalisation engine. Two requesters (adder path id 0,
// multiplier path id 1) are round-robin arbitrated into a two-stage
// valid/ready pipeline. S1 captures the request; S2 holds the normalised
// mantissa, adjusted exponent, applied shift and zero/underflow flags.
module bf16_norm_arb #(
  parameter int M_W = 16,
  parameter int E_W = 8,
  parameter int C_W = $clog2(M_W + 1)
) (
  input  logic           clk,
  input  logic           nreset,
  input  logic           req0_valid_i,
  output logic           req0_ready_o,
  input  logic [M_W-1:0] req0_man_i,
  input  logic [E_W-1:0] req0_exp_i,
  input  logic           req1_valid_i,
  output logic           req1_ready_o,
  input  logic [M_W-1:0] req1_man_i,
  input  logic [E_W-1:0] req1_exp_i,
  output logic           res_valid_o,
  input  logic           res_ready_i,
  output logic           res_id_o,
  output logic [M_W-1:0] res_man_o,
  output logic [E_W-1:0] res_exp_o,
  output logic [C_W-1:0] res_cnt_o,
  output logic           res_zero_o,
  output logic           res_uf_o
);

  localparam int LVL = $clog2(M_W);
  // Common width for the exponent/count comparison and subtraction.
  localparam int X_W = (E_W > C_W) ? E_W : C_W;

  // S1 capture register and round-robin pointer.
  logic           s1_valid;
  logic           s1_id;
  logic [M_W-1:0] s1_man;
  logic [E_W-1:0] s1_exp;
  logic           ptr;

  // S2 result register.
  logic           s2_valid;
  logic           s2_id;
  logic [M_W-1:0] s2_man;
  logic [E_W-1:0] s2_exp;
  logic [C_W-1:0] s2_cnt;
  logic           s2_zero;
  logic           s2_uf;

  // Handshake and arbitration signals.
  logic           grant0;
  logic           grant1;
  logic           s2_load;
  logic           s1_load_en;
  logic           accept;
  logic           acc_id;

  // Normalisation datapath.
  logic [M_W-1:0] lz_win;
  logic [C_W-1:0] lzc;
  logic [X_W-1:0] exp_x;
  logic [X_W-1:0] cnt_x;
  logic [M_W-1:0] n_man;
  logic [E_W-1:0] n_exp;
  logic [C_W-1:0] n_cnt;
  logic           n_zero;
  logic           n_uf;

  assign s2_load    = s1_valid & (~s2_valid | res_ready_i);
  assign s1_load_en = ~s1_valid | s2_load;

  // Round-robin grant: a lone requester wins, on contention the pointer decides.
  always_comb begin
    grant0 = req0_valid_i & (~req1_valid_i | ~ptr);
    grant1 = req1_valid_i & (~req0_valid_i | ptr);
  end

  // Ready is forced low while reset is asserted so nothing looks accepted.
  assign req0_ready_o = grant0 & s1_load_en & nreset;
  assign req1_ready_o = grant1 & s1_load_en & nreset;
  assign accept       = req0_ready_o | req1_ready_o;
  assign acc_id       = req1_ready_o;

  // S1 capture and pointer update on acceptance.
  always_ff @(posedge clk or negedge nreset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!nreset) begin
      s1_valid <= 1'b0;
      s1_id    <= 1'b0;
      s1_man   <= '0;
      s1_exp   <= '0;
      ptr      <= 1'b0;
    end else if (s1_load_en) begin
      s1_valid <= accept;
      if (accept) begin
        s1_id  <= acc_id;
        s1_man <= acc_id ? req1_man_i : req0_man_i;
        s1_exp <= acc_id ? req1_exp_i : req0_exp_i;
        ptr    <= ~acc_id;
      end
    end
  end

  // Logarithmic leading-zero count: each level tests the upper half of the
  // remaining window and shifts it out when it is all zero.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned (which would infer a latch).
    lz_win = s1_man;
    lzc    = '0;
    for (int k = LVL - 1; k >= 0; k--) begin
      if ((lz_win >> (M_W - (1 << k))) == '0) begin
        lzc[k] = 1'b1;
        lz_win = lz_win << (1 << k);
      end
    end
    if (s1_man == '0) lzc = C_W'(M_W);
  end

  // Normalise, clamping the shift to the exponent when it would underflow.
  always_comb begin
    exp_x  = X_W'(s1_exp);
    cnt_x  = X_W'(lzc);
    n_man  = '0;
    n_exp  = '0;
    n_cnt  = C_W'(M_W);
    n_zero = 1'b0;
    n_uf   = 1'b0;
    if (s1_man == '0) begin
      n_zero = 1'b1;
    end else if (exp_x > cnt_x) begin
      n_man = s1_man << lzc;
      n_exp = E_W'(exp_x - cnt_x);
      n_cnt = lzc;
    end else begin
      // exp <= lzc < M_W here, so the exponent fits the count field.
      n_man = s1_man << s1_exp;
      n_cnt = C_W'(exp_x);
      n_uf  = 1'b1;
    end
  end

  // S2 result register; payload holds while the consumer stalls.
  always_ff @(posedge clk or negedge nreset) begin
    // NOTE: payload registers are reset too, because the outputs must read
    // zero during reset rather than stale data.
    if (!nreset) begin
      s2_valid <= 1'b0;
      s2_id    <= 1'b0;
      s2_man   <= '0;
      s2_exp   <= '0;
      s2_cnt   <= '0;
      s2_zero  <= 1'b0;
      s2_uf    <= 1'b0;
    end else if (s2_load) begin
      s2_valid <= 1'b1;
      s2_id    <= s1_id;
      s2_man   <= n_man;
      s2_exp   <= n_exp;
      s2_cnt   <= n_cnt;
      s2_zero  <= n_zero;
      s2_uf    <= n_uf;
    end else if (res_ready_i) begin
      s2_valid <= 1'b0;
    end
  end

  assign res_valid_o = s2_valid;
  assign res_id_o    = s2_id;
  assign res_man_o   = s2_man;
  assign res_exp_o   = s2_exp;
  assign res_cnt_o   = s2_cnt;
  assign res_zero_o  = s2_zero;
  assign res_uf_o    = s2_uf;

endmodule

// File: doc/bf16_norm_arb.md
Name: bf16_norm_arb

Overview:
- Shared normalisation engine that time-multiplexes one tree leading-zero counter and left shifter between two requesters: the adder path (id 0) and the multiplier path (id 1) of the BFloat16 datapath.
- Each request carries an unnormalised mantissa and an exponent. The block returns the normalised mantissa, the adjusted exponent, the shift count, and zero/underflow flags, tagged with the requester id.
- Two-stage valid/ready pipeline with round-robin arbitration and full backpressure.

Parameters:
- M_W, 16, mantissa width; must be a power of 2 and at least 4.
- E_W, 8, exponent width.
- C_W, $clog2(M_W+1), width of the leading-zero count.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- nreset  in  1  asynchronous active-low reset.
- req0_valid_i  in  1  requester 0 (adder) request valid.
- req0_ready_o  out  1  requester 0 accepted this cycle.
- req0_man_i  in  M_W  requester 0 mantissa.
- req0_exp_i  in  E_W  requester 0 exponent.
- req1_valid_i  in  1  requester 1 (multiplier) request valid.
- req1_ready_o  out  1  requester 1 accepted this cycle.
- req1_man_i  in  M_W  requester 1 mantissa.
- req1_exp_i  in  E_W  requester 1 exponent.
- res_valid_o  out  1  result valid.
- res_ready_i  in  1  consumer accepts result.
- res_id_o  out  1  id of the requester that owns the result.
- res_man_o  out  M_W  normalised mantissa.
- res_exp_o  out  E_W  adjusted exponent.
- res_cnt_o  out  C_W  shift amount actually applied.
- res_zero_o  out  1  input mantissa was zero.
- res_uf_o  out  1  normalisation clamped by the exponent (underflow).

Behaviour:
- Reset (async, nreset=0):
  - S1 and S2 valid flags are 0; the priority pointer is 0.
  - All res_* outputs are 0 and both ready outputs are 0.
  - Reset may assert mid-operation; in-flight entries are dropped with no partial outputs.
- Stage S1 (capture register):
  - s2_load = s1_valid & (~s2_valid | res_ready_i).
  - s1_load_en = ~s1_valid | s2_load.
- Arbitration:
  - Combinational and round-robin.
  - If exactly one requester is valid, it is granted.
  - If both are valid, the requester equal to the pointer is granted.
  - reqK_ready_o = grant_K & s1_load_en. At most one ready is high per cycle.
  - Ready may depend combinationally on the valids; a requester must hold valid and data stable until it sees ready.
- Handshake on acceptance: S1 captures {id, man, exp} and the pointer becomes ~id. The pointer is unchanged when nothing is accepted.
- Stage S2 (compute): on s2_load, S2 registers the results computed from S1.
  - cnt = leading-zero count of man, using the tree LZC over M_W bits; cnt = M_W when man = 0.
  - If man == 0: man_o = 0, exp_o = 0, cnt_o = M_W, zero = 1, uf = 0.
  - Else if exp > cnt: man_o = man << cnt, exp_o = exp - cnt, cnt_o = cnt, uf = 0.
  - Else (exp <= cnt): man_o = man << exp, exp_o = 0, cnt_o = exp, uf = 1.
  - The shift is logical, zero-filled, and truncated to M_W bits. The subtraction is unsigned and never wraps.
- Output:
  - res_valid_o = s2_valid.
  - The payload is held stable while res_valid_o=1 and res_ready_i=0.
  - s2_valid clears on a handshake unless s2_load occurs in the same cycle.
- Latency and throughput:
  - A request accepted at edge N produces res_valid_o=1 after edge N+1.
  - Throughput is 1 result per cycle with res_ready_i held at 1.
- Capacity and backpressure: 2 entries total (S1 and S2). With both stages full and res_ready_i=0, both ready outputs are 0.
- Simultaneous events: an output handshake, an S1-to-S2 move, and a new acceptance may all occur in the same cycle with no bubble.

Test Plan:
- Single request, adder port: req0 man=0x0010, exp=20, res_ready_i=1 -> 2 cycles later res_valid_o=1, id=0, man=0x8000, exp=9, cnt=11, zero=0, uf=0.
- Zero mantissa, multiplier port: req1 man=0x0000, exp=100 -> man=0, exp=0, cnt=16, zero=1, uf=0, id=1.
- Underflow clamp: req0 man=0x0001, exp=5 -> man=0x0020, exp=0, cnt=5, uf=1. Boundary case man=0x0001, exp=16 -> man=0x0000... shift 15 is not applied because exp > cnt (16 > 15), so man=0x8000, exp=1, cnt=15, uf=0.
- Contention: both requesters continuously valid for 6 cycles with distinct data, res_ready_i=1 -> grants alternate 0,1,0,1,0,1 starting from the reset pointer 0, and res_id_o follows the same order.
- Backpressure: res_ready_i=0 with both requesters valid -> exactly 2 acceptances, then both ready outputs stay 0 and the S2 payload is stable. Releasing res_ready_i -> results drain in acceptance order with no loss or duplication.
- Reset mid-operation: assert nreset=0 with both stages full -> outputs go to 0 immediately and the pointer returns to 0. After release, a single request completes with the 2-cycle latency.
